// File: rtl/hc85_seq_cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Contents:
//   state_t      - controller states (IDLE, CMP)
//   res_t        - 3-bit result {gt, lt, eq} driven onto QAGB/QASB/QAEB
//   calc_nslice  - number of slices for a given operand/slice width
//   cascade_res  - maps the cascade inputs to the all-slices-equal result
package hc85_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } res_t;

    localparam res_t RES_GT   = 3'b100;
    localparam res_t RES_LT   = 3'b010;
    localparam res_t RES_EQ   = 3'b001;
    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_BOTH = 3'b110;

    function automatic int calc_nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // IAEB dominates; otherwise the two magnitude cascade inputs pass through
    // inverted-for-both-high / both-set-for-both-low, like the original part.
    function automatic res_t cascade_res(input logic iagb, input logic iasb,
                                         input logic iaeb);
        res_t r;
        if (iaeb) begin
            r = RES_EQ;
        end else begin
            case ({iagb, iasb})
                2'b10:   r = RES_GT;
                2'b01:   r = RES_LT;
                2'b11:   r = RES_NONE;
                default: r = RES_BOTH;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/hc85_seq_cmp_if.sv
// Request/result bundle for hc85_seq_cmp.
// master: drives START, SGN, A, B, IAGB, IASB, IAEB; observes BUSY, DONE, Q*.
// slave : the comparator side of the same signals.
interface hc85_seq_cmp_if #(
    parameter int WIDTH = 16
);
    logic             START;
    logic             SGN;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             IAGB;
    logic             IASB;
    logic             IAEB;
    logic             BUSY;
    logic             DONE;
    logic             QAGB;
    logic             QASB;
    logic             QAEB;

    modport master (
        output START, SGN, A, B, IAGB, IASB, IAEB,
        input  BUSY, DONE, QAGB, QASB, QAEB
    );

    modport slave (
        input  START, SGN, A, B, IAGB, IASB, IAEB,
        output BUSY, DONE, QAGB, QASB, QAEB
    );
endinterface

// File: rtl/hc85_slice_cmp.sv
// Combinational unsigned compare of one SLICE-bit slice.
// Ports: a, b (slice operands) -> gt, lt, eq (exactly one high).
module hc85_slice_cmp #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);
    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);
endmodule

// File: rtl/hc85_seq_cmp.sv
// Sequential WIDTH-bit magnitude comparator, one SLICE-bit slice per clock,
// MSB slice first, stopping at the first unequal slice. Falls back to the
// 74HC85 cascade inputs when every slice is equal. Optional signed mode.
// Ports:
//   CLK  - rising-edge clock
//   RSTN - asynchronous active-low reset
//   bus  - slave side of hc85_seq_cmp_if (START/SGN/A/B/I* in,
//          BUSY/DONE/QAGB/QASB/QAEB out)
module hc85_seq_cmp
    import hc85_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    hc85_seq_cmp_if.slave    bus
);
    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0]  TOP_IDX  = IDXW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t           state_reg, state_next;
    logic [IDXW-1:0]  idx_reg, idx_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    res_t             casc_reg;
    res_t             res_reg, res_next;
    logic             done_reg, done_next;
    logic             load;

    logic [SLICE-1:0] a_slices [NSLICE];
    logic [SLICE-1:0] b_slices [NSLICE];
    logic             s_gt, s_lt, s_eq;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slices
            assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
            assign b_slices[gi] = b_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    hc85_slice_cmp #(.SLICE(SLICE)) u_slice (
        .a  (a_slices[idx_reg]),
        .b  (b_slices[idx_reg]),
        .gt (s_gt),
        .lt (s_lt),
        .eq (s_eq)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        res_next   = res_reg;
        done_next  = 1'b0;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.START) begin
                    load       = 1'b1;
                    idx_next   = TOP_IDX;
                    state_next = CMP;
                end
            end
            CMP: begin
                if (!s_eq) begin
                    res_next   = {s_gt, s_lt, 1'b0};
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (idx_reg == '0) begin
                    res_next   = casc_reg;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            casc_reg  <= RES_NONE;
            res_reg   <= RES_NONE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            res_reg   <= res_next;
            done_reg  <= done_next;
            if (load) begin
                // Flipping both sign bits turns a two's-complement compare
                // into an unsigned one, so only the top slice is affected.
                a_reg    <= bus.SGN ? (bus.A ^ MSB_MASK) : bus.A;
                b_reg    <= bus.SGN ? (bus.B ^ MSB_MASK) : bus.B;
                casc_reg <= cascade_res(bus.IAGB, bus.IASB, bus.IAEB);
            end
        end
    end

    assign bus.BUSY = (state_reg == CMP);
    assign bus.DONE = done_reg;
    assign bus.QAGB = res_reg.gt;
    assign bus.QASB = res_reg.lt;
    assign bus.QAEB = res_reg.eq;

endmodule

// File: tb/tb_hc85_seq_cmp.sv
module tb_hc85_seq_cmp;
    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    logic CLK  = 1'b0;
    logic RSTN = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    hc85_seq_cmp_if #(.WIDTH(WIDTH)) bus ();

    hc85_seq_cmp #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic compare; k from the highest differing bit.
    function automatic logic [2:0] casc_model(input logic ag, input logic as_, input logic ae);
        if (ae) return 3'b001;
        if (ag && !as_) return 3'b100;
        if (!ag && as_) return 3'b010;
        if (ag && as_) return 3'b000;
        return 3'b110;
    endfunction

    task automatic model_eval(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic sgn, input logic ag, input logic as_, input logic ae,
                              output int k, output logic [2:0] q);
        logic [WIDTH-1:0] x;
        logic signed [WIDTH-1:0] sa, sb;
        int p;
        x = a ^ b;
        sa = a;
        sb = b;
        if (x == '0) begin
            k = NSLICE;
            q = casc_model(ag, as_, ae);
        end else begin
            p = 0;
            for (int i = 0; i < WIDTH; i++) if (x[i]) p = i;
            k = NSLICE - p / SLICE;
            if (sgn) q = (sa > sb) ? 3'b100 : 3'b010;
            else     q = (a > b)   ? 3'b100 : 3'b010;
        end
    endtask

    // Cycle-level expectation tracker built on the reference above.
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [2:0] m_q    = 3'b000;
    logic [2:0] m_pend = 3'b000;
    int         m_left = 0;

    always @(posedge CLK or negedge RSTN) begin
        int k;
        logic [2:0] q;
        if (!RSTN) begin
            m_busy = 1'b0; m_done = 1'b0; m_q = 3'b000; m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_q = m_pend;
            end else begin
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (bus.START) begin
                model_eval(bus.A, bus.B, bus.SGN, bus.IAGB, bus.IASB, bus.IAEB, k, q);
                m_busy = 1'b1; m_left = k; m_pend = q;
            end
        end
    end

    always @(negedge CLK) begin
        chk("cyc_busy", {31'b0, bus.BUSY}, {31'b0, m_busy});
        chk("cyc_done", {31'b0, bus.DONE}, {31'b0, m_done});
        chk("cyc_q", {29'b0, bus.QAGB, bus.QASB, bus.QAEB}, {29'b0, m_q});
    end

    task automatic run_cmp(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic sgn, input logic ag, input logic as_, input logic ae,
                           input int exp_k, input logic [2:0] exp_q, input bit scramble);
        int n;
        int busy_cyc;
        @(negedge CLK);
        bus.A = a; bus.B = b; bus.SGN = sgn;
        bus.IAGB = ag; bus.IASB = as_; bus.IAEB = ae;
        bus.START = 1'b1;
        n = 0;
        busy_cyc = 0;
        do begin
            @(negedge CLK);
            n++;
            if (bus.BUSY) busy_cyc++;
            bus.START = scramble ? 1'($urandom) : 1'b0;
            if (scramble) begin
                bus.A = 16'($urandom); bus.B = 16'($urandom); bus.SGN = 1'($urandom);
                bus.IAGB = 1'($urandom); bus.IASB = 1'($urandom); bus.IAEB = 1'($urandom);
            end
        end while (!bus.DONE && n < 40);
        bus.START = 1'b0;
        chk({name, "_k"}, 32'(n - 1), 32'(exp_k));
        chk({name, "_busy"}, 32'(busy_cyc), 32'(exp_k));
        chk({name, "_q"}, {29'b0, bus.QAGB, bus.QASB, bus.QAEB}, {29'b0, exp_q});
        $display("txn %s A=%h B=%h SGN=%0d I=%0d%0d%0d k=%0d Q=%0d%0d%0d", name, a, b, sgn,
                 ag, as_, ae, n - 1, bus.QAGB, bus.QASB, bus.QAEB);
    endtask

    initial begin
        int dn;
        bus.START = 1'b0; bus.SGN = 1'b0; bus.A = '0; bus.B = '0;
        bus.IAGB = 1'b0; bus.IASB = 1'b0; bus.IAEB = 1'b0;
        #1 RSTN = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", {31'b0, bus.BUSY}, 32'd0);
        chk("rst_done", {31'b0, bus.DONE}, 32'd0);
        chk("rst_q", {29'b0, bus.QAGB, bus.QASB, bus.QAEB}, 32'd0);
        #2 RSTN = 1'b1;

        run_cmp("msb_diff",  16'h8000, 16'h7FFF, 0, 0, 0, 0, 1, 3'b100, 0);
        run_cmp("eq_iaeb",   16'h1234, 16'h1234, 0, 0, 0, 1, 4, 3'b001, 0);
        run_cmp("eq_low",    16'h1234, 16'h1234, 0, 0, 0, 0, 4, 3'b110, 0);
        run_cmp("eq_gt",     16'hABCD, 16'hABCD, 0, 1, 0, 0, 4, 3'b100, 0);
        run_cmp("eq_lt",     16'hABCD, 16'hABCD, 0, 0, 1, 0, 4, 3'b010, 0);
        run_cmp("eq_both",   16'h0000, 16'h0000, 0, 1, 1, 0, 4, 3'b000, 0);
        run_cmp("eq_ae_dom", 16'hFFFF, 16'hFFFF, 1, 1, 1, 1, 4, 3'b001, 0);
        run_cmp("sgn_neg",   16'hFFFF, 16'h0001, 1, 0, 0, 0, 1, 3'b010, 0);
        run_cmp("uns_big",   16'hFFFF, 16'h0001, 0, 0, 0, 0, 1, 3'b100, 0);
        run_cmp("sgn_min",   16'h8000, 16'h7FFF, 1, 0, 0, 0, 1, 3'b010, 0);
        run_cmp("slice2",    16'h1200, 16'h1300, 0, 0, 0, 0, 2, 3'b010, 0);
        run_cmp("slice3",    16'h1244, 16'h1234, 0, 0, 0, 0, 3, 3'b100, 0);
        run_cmp("lsb_scr",   16'h1235, 16'h1234, 0, 0, 0, 0, 4, 3'b100, 1);

        // START held: k=1 so a compare completes every 2 cycles.
        @(negedge CLK);
        bus.A = 16'h8000; bus.B = 16'h7FFF; bus.SGN = 1'b0;
        bus.IAGB = 1'b0; bus.IASB = 1'b0; bus.IAEB = 1'b0;
        bus.START = 1'b1;
        dn = 0;
        repeat (10) begin
            @(negedge CLK);
            if (bus.DONE) dn++;
        end
        bus.START = 1'b0;
        chk("b2b_dones", 32'(dn), 32'd5);
        $display("txn b2b A=8000 B=7FFF dones=%0d", dn);

        // Abort a 4-slice compare partway through.
        @(negedge CLK);
        bus.A = 16'h1234; bus.B = 16'h1234; bus.IAEB = 1'b1;
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        @(negedge CLK);
        #2 RSTN = 1'b0;
        #1;
        chk("abort_busy", {31'b0, bus.BUSY}, 32'd0);
        chk("abort_done", {31'b0, bus.DONE}, 32'd0);
        chk("abort_q", {29'b0, bus.QAGB, bus.QASB, bus.QAEB}, 32'd0);
        @(negedge CLK);
        #2 RSTN = 1'b1;
        dn = 0;
        repeat (6) begin
            @(negedge CLK);
            if (bus.DONE) dn++;
        end
        chk("abort_nodone", 32'(dn), 32'd0);
        $display("txn abort A=1234 B=1234 dones_after=%0d", dn);

        run_cmp("post_rst",  16'h0001, 16'h0002, 0, 0, 0, 0, 4, 3'b010, 0);

        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
